// File: rtl/sram_pkg.sv
// Shared types and default widths for the asynchronous SRAM front-end.
package sram_pkg;

   localparam int SRAM_ADDR_W = 8;
   localparam int SRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } sram_state_t;

   // Wait-counter width; a single-cycle strobe still needs a 1-bit counter.
   function automatic int cnt_width(input int rd_wait, input int wr_wait);
      int m;
      m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/tristate_buf.sv
// Bus driver with output enable; keeps bus-direction logic in one place for all bus masters.
module tristate_buf #(
   parameter int W = 8
) (
   input  logic         oe,
   input  logic [W-1:0] d,
   inout  wire  [W-1:0] bus
);

   assign bus = oe ? d : {W{1'bz}};

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front-end sequencing address, strobes and data bus for an asynchronous SRAM.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int DATA_W  = SRAM_DATA_W,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we_n,
   output logic              mem_oe_n,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   generate
      if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
         $error("sram_ctrl: RD_WAIT and WR_WAIT must both be >= 1");
      end
   endgenerate

   sram_state_t       state;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              drive;

   tristate_buf #(.W(DATA_W)) u_bus (
      .oe  (drive),
      .d   (wdata_q),
      .bus (mem_data)
   );

   // NOTE: every register here uses <= so all branches see pre-edge values; a blocking
   // assignment would let the ACCESS test observe a counter already decremented this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         mem_addr  <= '0;
         mem_we_n  <= 1'b1;
         mem_oe_n  <= 1'b1;
         drive     <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         cnt       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  write_q   <= req_write;
                  wdata_q   <= req_wdata;
                  mem_addr  <= req_addr;
                  req_ready <= 1'b0;
                  state     <= SETUP;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            // Address has been stable for one cycle; now drop exactly one strobe.
            SETUP: begin
               cnt <= write_q ? WR_LOAD : RD_LOAD;
               if (write_q) begin
                  mem_we_n <= 1'b0;
                  drive    <= 1'b1;
               end else begin
                  mem_oe_n <= 1'b0;
               end
               state <= ACCESS;
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (write_q) begin
                     mem_we_n <= 1'b1;
                     state    <= HOLD;
                  end else begin
                     mem_oe_n  <= 1'b1;
                     rsp_rdata <= mem_data;
                     rsp_valid <= 1'b1;
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            // Strobe is already high; keep data on the bus one more cycle for hold time.
            HOLD: begin
               drive     <= 1'b0;
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
